lcd_value_sequencer: RTL
========================

Name: lcd_value_sequencer

Overview:
Sequencer that renders one 32-bit unsigned value on line 1 of the character LCD.
- Converts the value to decimal.
- Issues 16 transfers to the lcd driver over its data_ready / busy_flag handshake: DDRAM address command, "E=", 10 digits with leading-zero blanking, " Wh".
- Replaces the fixed ROM/controller path; sits between the energy-measurement logic and the lcd module.

Parameters:
- LINE_ADDR, 8'h80, Set-DDRAM-address command byte sent first (rs=0).
- ACK_TIMEOUT, 16, cycles to wait for lcd_busy to rise after a data_ready pulse before re-pulsing.

Ports:
- clock  in  1  system clock (100 MHz).
- internal_reset  in  1  synchronous, active-high reset.
- value  in  32  unsigned value to display.
- value_valid  in  1  one-cycle strobe; value is sampled when high.
- lcd_busy  in  1  lcd driver busy_flag.
- d_out  out  9  {rs, data[7:0]} to lcd driver d_in.
- data_ready  out  1  one-cycle request pulse to lcd driver.
- idle  out  1  high when no frame is in progress and none is pending.

Behaviour:
- Reset values: d_out=9'h000, data_ready=0, idle=1, pending flag=0, index=0, FSM=IDLE.
- Reset has priority over all other actions and may occur in any state; after reset no data_ready is issued until a new value_valid.
- Capture in IDLE:
  - value_valid=1 -> copy value into shadow register, go to CONVERT.
  - value_valid in any other state -> store in pending register and set pending; a later strobe overwrites it (last wins).
- CONVERT: sequential double-dabble, exactly 32 cycles, 10 BCD digits. Max 4294967295 fits 10 digits.
- Frame sequence, index 0..15:
  - 0: {0, LINE_ADDR}
  - 1-2: {1,"E"}, {1,"="}
  - 3-12: digits, most significant first. Digit = 8'h30+bcd. Leading zeros become 8'h20 (space); digit 12 is never blanked.
  - 13-15: {1," "}, {1,"W"}, {1,"h"}.
- FSM states: IDLE, CONVERT, LOAD, PULSE, WAIT_ACK, WAIT_DONE, NEXT.
  - LOAD: drive d_out for the current index. Proceed to PULSE only when lcd_busy=0 (covers the lcd power-on init, where busy stays high for ~100 ms).
  - PULSE: data_ready=1 for exactly one cycle.
  - WAIT_ACK: wait for lcd_busy=1. After ACK_TIMEOUT cycles without it, return to PULSE; a re-pulse is harmless because the driver's start is sticky.
  - WAIT_DONE: wait for lcd_busy=0, then go to NEXT.
  - NEXT: increment index. Index 15 done -> if pending, clear pending, load the pending value into the shadow register, go to CONVERT; otherwise go to IDLE.
- d_out must be stable from LOAD through WAIT_DONE: at least one cycle before data_ready and unchanged until busy falls.
- Latency: with lcd idle, value_valid sampled at cycle 0 -> data_ready at cycle 35 (1 capture + 32 convert + LOAD + PULSE).
- The shadow value is never altered mid-frame; the displayed frame is always self-consistent.
- idle = (FSM==IDLE) && !pending.

Decomposition:
- Package lcd_pkg: FSM state encoding, CMD_SET_DDRAM, character constants (CHAR_SPACE 8'h20, CHAR_ZERO 8'h30, "E", "=", "W", "h"), frame length 16, digit count 10.
- Sub-module bin2bcd_seq (clock, internal_reset, start, bin[31:0], busy, done, bcd[39:0]). Iterative shift-add-3, 32 cycles, one-cycle done pulse.
- Top-level mux selects the character by index.

Test Plan:
- value=1234, lcd model acknowledging busy after 2 cycles, 10-cycle transfer -> exactly 16 transfers: 0x080, 0x145, 0x13D, six 0x120, 0x131, 0x132, 0x133, 0x134, 0x120, 0x157, 0x168; then idle=1.
- value=0 -> digits 3-11 are 0x120, digit 12 is 0x130.
- value=32'hFFFFFFFF -> digits "4294967295", no blanking; first data_ready exactly 35 cycles after value_valid.
- lcd_busy held high 1000 cycles at start -> no data_ready until busy falls; d_out=0x080 held. Model that never raises busy -> re-pulse every ACK_TIMEOUT+1 cycles.
- Strobes 5, then 6, then 7 during a frame -> frame "5" completes, then a single frame "7"; "6" is never shown.
- internal_reset asserted during WAIT_DONE at index 7 -> next cycle data_ready=0, d_out=0, idle=1; a subsequent value_valid starts from index 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and BCD helper for the LCD value sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StLoad,
    StPulse,
    StWaitAck,
    StWaitDone,
    StNext
  } seq_state_t;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_E     = 8'h45;
  localparam logic [7:0] CHAR_EQ    = 8'h3D;
  localparam logic [7:0] CHAR_W     = 8'h57;
  localparam logic [7:0] CHAR_H     = 8'h68;

  localparam int unsigned FRAME_LEN       = 16;
  localparam int unsigned NUM_DIGITS      = 10;
  localparam int unsigned BCD_W           = 4 * NUM_DIGITS;
  localparam int unsigned FIRST_DIGIT_IDX = 3;

  // Double-dabble correction: add 3 to every digit that is 5 or more before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_value_sequencer_bin2bcd.sv
// Iterative 32-bit binary to 10-digit BCD converter (shift-add-3, 32 cycles).
module bin2bcd_seq
  import lcd_pkg::*;
(
  input  logic             clock,
  input  logic             internal_reset,
  input  logic             start,
  input  logic [31:0]      bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [31:0]      shreg;
  logic [4:0]       count;
  logic [BCD_W-1:0] adj;

  // Digit correction applied ahead of each shift.
  always_comb begin
    adj = bcd_adjust(bcd);
  end

  // Load on start, then 32 shift steps; done pulses with the final step.
  always_ff @(posedge clock) begin
    if (internal_reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= 5'd0;
      shreg <= 32'd0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        {bcd, shreg} <= {adj, shreg} << 1;
        count        <= count + 5'd1;
        if (count == 5'd31) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        shreg <= bin;
        bcd   <= '0;
        count <= 5'd0;
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_value_sequencer.sv
// Renders a 32-bit value as "E=<10 digits> Wh" on LCD line 1 via the driver handshake.
module lcd_value_sequencer
  import lcd_pkg::*;
#(
  parameter logic [7:0]  LINE_ADDR   = CMD_SET_DDRAM,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        internal_reset,
  input  logic [31:0] value,
  input  logic        value_valid,
  input  logic        lcd_busy,
  output logic [8:0]  d_out,
  output logic        data_ready,
  output logic        idle
);

  localparam logic [3:0] LAST_IDX       = 4'(FRAME_LEN - 1);
  localparam logic [3:0] FIRST_DIGIT    = 4'(FIRST_DIGIT_IDX);
  localparam logic [3:0] LAST_DIGIT_IDX = 4'(FIRST_DIGIT_IDX + NUM_DIGITS - 1);

  seq_state_t       state;
  logic [31:0]      shadow;
  logic [31:0]      pend_value;
  logic             pending;
  logic [3:0]       idx;
  logic [15:0]      timer;
  logic             conv_start;
  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] bcd;

  logic [3:0]       char_idx;
  logic [3:0]       digit_pos;
  logic [5:0]       digit_shift;
  logic [BCD_W-1:0] shifted;
  logic             lead_zero;
  logic [8:0]       frame_char;

  bin2bcd_seq u_bin2bcd (
    .clock          (clock),
    .internal_reset (internal_reset),
    .start          (conv_start),
    .bin            (shadow),
    .busy           (conv_busy),
    .done           (conv_done),
    .bcd            (bcd)
  );

  // Character for the slot about to be loaded; NEXT looks one index ahead.
  always_comb begin
    char_idx    = (state == StNext) ? idx + 4'd1 : idx;
    digit_pos   = char_idx - FIRST_DIGIT;
    digit_shift = 6'd36 - {digit_pos, 2'b00};
    shifted     = bcd >> digit_shift;
    // A digit is blank when it and everything above it is zero; the units digit always shows.
    lead_zero   = (shifted == '0) && (char_idx != LAST_DIGIT_IDX);
    frame_char  = 9'h000;
    case (char_idx)
      4'd0:    frame_char = {1'b0, LINE_ADDR};
      4'd1:    frame_char = {1'b1, CHAR_E};
      4'd2:    frame_char = {1'b1, CHAR_EQ};
      4'd13:   frame_char = {1'b1, CHAR_SPACE};
      4'd14:   frame_char = {1'b1, CHAR_W};
      4'd15:   frame_char = {1'b1, CHAR_H};
      default: frame_char = {1'b1, lead_zero ? CHAR_SPACE : (CHAR_ZERO | {4'h0, shifted[3:0]})};
    endcase
  end

  // Frame sequencer: capture, convert, then 16 handshaked transfers.
  always_ff @(posedge clock) begin
    if (internal_reset) begin
      state      <= StIdle;
      shadow     <= 32'd0;
      pend_value <= 32'd0;
      pending    <= 1'b0;
      idx        <= 4'd0;
      timer      <= 16'd0;
      conv_start <= 1'b0;
      d_out      <= 9'h000;
      data_ready <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      data_ready <= 1'b0;
      unique case (state)
        StIdle: begin
          if (value_valid) begin
            shadow     <= value;
            conv_start <= 1'b1;
            idx        <= 4'd0;
            state      <= StConvert;
          end else if (pending) begin
            // A strobe that landed on the last NEXT cycle is picked up here.
            shadow     <= pend_value;
            pending    <= 1'b0;
            conv_start <= 1'b1;
            idx        <= 4'd0;
            state      <= StConvert;
          end
        end
        StConvert: begin
          if (conv_done && !conv_busy) begin
            d_out <= frame_char;
            state <= StLoad;
          end
        end
        StLoad: begin
          // d_out was set on entry, so it leads data_ready by at least a cycle.
          if (!lcd_busy) begin
            data_ready <= 1'b1;
            state      <= StPulse;
          end
        end
        StPulse: begin
          timer <= 16'd0;
          state <= StWaitAck;
        end
        StWaitAck: begin
          if (lcd_busy) begin
            state <= StWaitDone;
          end else if (timer == 16'(ACK_TIMEOUT - 1)) begin
            // Driver start is sticky, so a repeated request cannot double-transfer.
            data_ready <= 1'b1;
            state      <= StPulse;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        StWaitDone: begin
          if (!lcd_busy) begin
            state <= StNext;
          end
        end
        StNext: begin
          if (idx == LAST_IDX) begin
            idx <= 4'd0;
            if (pending) begin
              shadow     <= pend_value;
              pending    <= 1'b0;
              conv_start <= 1'b1;
              state      <= StConvert;
            end else begin
              state <= StIdle;
            end
          end else begin
            idx   <= idx + 4'd1;
            d_out <= frame_char;
            state <= StLoad;
          end
        end
        default: state <= StIdle;
      endcase
      // Placed after the case so a strobe in the consuming NEXT cycle is not lost.
      if (value_valid && (state != StIdle)) begin
        pend_value <= value;
        pending    <= 1'b1;
      end
    end
  end

  assign idle = (state == StIdle) && !pending;

endmodule
